mem_dual_ram: RTL and testbench

Parametrised dual-port on-chip RAM for the core's instruction and data paths. It replaces the fixed-latency, always-accepting memory model with valid/ready request and response channels, configurable read latency, a per-byte write strobe of generic width and address-range checking. One instruction read port; one data port that accepts reads and writes.

---
 rtl/mem_dual_ram.sv | 199 +++++++++++++++++++
 tb/tb_mem_dual_ram.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dual_ram.sv
// Dual-port on-chip RAM: one instruction read port and one data read/write port,
// each with valid/ready request and response channels and a RD_LATENCY-deep pipeline.
// Optional build macro MEM_TRACE_EN adds a $display transaction trace with a cycle counter.
module mem_dual_ram #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 12,
    parameter int                    RD_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic                      pInst_bReqValid,
    output logic                      pInst_bReqReady,
    input  logic [ADDR_WIDTH-1:0]     pInst_bReqAddr,
    output logic                      pInst_bRspValid,
    input  logic                      pInst_bRspReady,
    output logic [DATA_WIDTH-1:0]     pInst_bRspData,
    output logic                      pInst_bRspErr,
    input  logic                      pData_bReqValid,
    output logic                      pData_bReqReady,
    input  logic                      pData_bReqWr,
    input  logic [ADDR_WIDTH-1:0]     pData_bReqAddr,
    input  logic [DATA_WIDTH-1:0]     pData_bReqData,
    input  logic [DATA_WIDTH/8-1:0]   pData_bReqStrb,
    output logic                      pData_bRspValid,
    input  logic                      pData_bRspReady,
    output logic [DATA_WIDTH-1:0]     pData_bRspData,
    output logic                      pData_bRspErr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int WORDS  = 1 << DEPTH_LOG2;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
    localparam int LAST   = RD_LATENCY - 1;

    // Misaligned, below the base, or past the last word.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a < BASE_ADDR) || ((a & ALIGN_MASK) != '0) ||
               ((off >> (OFF_W + DEPTH_LOG2)) != '0);
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> OFF_W);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] w;
        w = old_w;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) w[8*b +: 8] = new_w[8*b +: 8];
        end
        return w;
    endfunction

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic                  inst_stall, data_stall, inst_acc, data_acc;
    logic                  inst_err, data_err, data_wr_en;
    logic [DEPTH_LOG2-1:0] inst_idx, data_idx;
    logic [DATA_WIDTH-1:0] data_word, data_merged, inst_rd_word;

    logic                  inst_vld_p  [RD_LATENCY];
    logic                  inst_err_p  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] inst_data_p [RD_LATENCY];
    logic                  data_vld_p  [RD_LATENCY];
    logic                  data_wr_p   [RD_LATENCY];
    logic                  data_err_p  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] data_data_p [RD_LATENCY];

    // A port freezes only while its output holds an unconsumed response.
    assign inst_stall      = inst_vld_p[LAST] && !pInst_bRspReady;
    assign data_stall      = data_vld_p[LAST] && !pData_bRspReady;
    assign pInst_bReqReady = !inst_stall;
    assign pData_bReqReady = !data_stall;
    assign inst_acc        = pInst_bReqValid && !inst_stall;
    assign data_acc        = pData_bReqValid && !data_stall;

    assign inst_err   = addr_err(pInst_bReqAddr);
    assign data_err   = addr_err(pData_bReqAddr);
    assign inst_idx   = addr_idx(pInst_bReqAddr);
    assign data_idx   = addr_idx(pData_bReqAddr);
    assign data_wr_en = data_acc && pData_bReqWr && !data_err && !iReset;

    // Array read at accept time; a same-cycle write to the same word is forwarded.
    always_comb begin
        data_word    = mem[data_idx];
        data_merged  = merge_bytes(data_word, pData_bReqData, pData_bReqStrb);
        inst_rd_word = mem[inst_idx];
        if (data_wr_en && (data_idx == inst_idx)) inst_rd_word = data_merged;
    end

    // Write commits at the accept edge with only strobed bytes changed.
    always_ff @(posedge iClock) begin
        if (data_wr_en) mem[data_idx] <= data_merged;
    end

    // Pipeline valid bits; reset discards everything in flight.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                inst_vld_p[k] <= 1'b0;
                data_vld_p[k] <= 1'b0;
            end
        end else begin
            if (!inst_stall) begin
                inst_vld_p[0] <= inst_acc;
                for (int k = 1; k < RD_LATENCY; k++) inst_vld_p[k] <= inst_vld_p[k-1];
            end
            if (!data_stall) begin
                data_vld_p[0] <= data_acc;
                for (int k = 1; k < RD_LATENCY; k++) data_vld_p[k] <= data_vld_p[k-1];
            end
        end
    end

    // Payload travels beside the valid bits; captured read data is never re-read.
    always_ff @(posedge iClock) begin
        if (!inst_stall) begin
            inst_err_p[0]  <= inst_err;
            inst_data_p[0] <= inst_rd_word;
            for (int k = 1; k < RD_LATENCY; k++) begin
                inst_err_p[k]  <= inst_err_p[k-1];
                inst_data_p[k] <= inst_data_p[k-1];
            end
        end
        if (!data_stall) begin
            data_wr_p[0]   <= pData_bReqWr;
            data_err_p[0]  <= data_err;
            data_data_p[0] <= data_word;
            for (int k = 1; k < RD_LATENCY; k++) begin
                data_wr_p[k]   <= data_wr_p[k-1];
                data_err_p[k]  <= data_err_p[k-1];
                data_data_p[k] <= data_data_p[k-1];
            end
        end
    end

    // Output stage: data is forced to zero for writes, errors and idle slots.
    assign pInst_bRspValid = inst_vld_p[LAST];
    assign pInst_bRspErr   = inst_vld_p[LAST] && inst_err_p[LAST];
    assign pInst_bRspData  = (inst_vld_p[LAST] && !inst_err_p[LAST]) ? inst_data_p[LAST] : '0;
    assign pData_bRspValid = data_vld_p[LAST];
    assign pData_bRspErr   = data_vld_p[LAST] && data_err_p[LAST];
    assign pData_bRspData  = (data_vld_p[LAST] && !data_wr_p[LAST] && !data_err_p[LAST]) ?
                             data_data_p[LAST] : '0;

`ifdef MEM_TRACE_EN
    logic [63:0]           trace_cyc;
    logic [ADDR_WIDTH-1:0] inst_addr_p [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] data_addr_p [RD_LATENCY];
    logic [STRB_W-1:0]     data_strb_p [RD_LATENCY];

    // Free-running cycle stamp for the trace.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) trace_cyc <= '0;
        else        trace_cyc <= trace_cyc + 64'd1;
    end

    // Carry request address/strobe to the response and print every handshake.
    always_ff @(posedge iClock) begin
        if (!inst_stall) begin
            inst_addr_p[0] <= pInst_bReqAddr;
            for (int k = 1; k < RD_LATENCY; k++) inst_addr_p[k] <= inst_addr_p[k-1];
        end
        if (!data_stall) begin
            data_addr_p[0] <= pData_bReqAddr;
            data_strb_p[0] <= pData_bReqStrb;
            for (int k = 1; k < RD_LATENCY; k++) begin
                data_addr_p[k] <= data_addr_p[k-1];
                data_strb_p[k] <= data_strb_p[k-1];
            end
        end
        if (!iReset) begin
            if (inst_acc)
                $display("[%0d] inst req rd addr=%h err=%b", trace_cyc, pInst_bReqAddr, inst_err);
            if (data_acc)
                $display("[%0d] data req %s addr=%h data=%h strb=%h err=%b", trace_cyc,
                         pData_bReqWr ? "wr" : "rd", pData_bReqAddr, pData_bReqData,
                         pData_bReqStrb, data_err);
            if (pInst_bRspValid && pInst_bRspReady)
                $display("[%0d] inst rsp rd addr=%h data=%h err=%b", trace_cyc,
                         inst_addr_p[LAST], pInst_bRspData, pInst_bRspErr);
            if (pData_bRspValid && pData_bRspReady)
                $display("[%0d] data rsp %s addr=%h data=%h strb=%h err=%b", trace_cyc,
                         data_wr_p[LAST] ? "wr" : "rd", data_addr_p[LAST], pData_bRspData,
                         data_strb_p[LAST], pData_bRspErr);
        end
    end
`endif

endmodule

// File: tb/tb_mem_dual_ram.sv
// Scoreboard bench for mem_dual_ram: accepted requests push expected responses,
// a monitor pops and compares data, error flag and arrival cycle.
module tb_mem_dual_ram;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DL    = 6;
    localparam int          LAT   = 3;
    localparam int          WORDS = 1 << DL;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic          iClock = 1'b0;
    logic          iReset;
    logic          pInst_bReqValid, pInst_bReqReady, pInst_bRspValid, pInst_bRspReady, pInst_bRspErr;
    logic [AW-1:0] pInst_bReqAddr;
    logic [DW-1:0] pInst_bRspData;
    logic          pData_bReqValid, pData_bReqReady, pData_bReqWr;
    logic          pData_bRspValid, pData_bRspReady, pData_bRspErr;
    logic [AW-1:0] pData_bReqAddr;
    logic [DW-1:0] pData_bReqData, pData_bRspData;
    logic [3:0]    pData_bReqStrb;

    mem_dual_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL),
                   .RD_LATENCY(LAT), .BASE_ADDR(BASE)) dut (
        .iClock(iClock), .iReset(iReset),
        .pInst_bReqValid(pInst_bReqValid), .pInst_bReqReady(pInst_bReqReady),
        .pInst_bReqAddr(pInst_bReqAddr), .pInst_bRspValid(pInst_bRspValid),
        .pInst_bRspReady(pInst_bRspReady), .pInst_bRspData(pInst_bRspData),
        .pInst_bRspErr(pInst_bRspErr),
        .pData_bReqValid(pData_bReqValid), .pData_bReqReady(pData_bReqReady),
        .pData_bReqWr(pData_bReqWr), .pData_bReqAddr(pData_bReqAddr),
        .pData_bReqData(pData_bReqData), .pData_bReqStrb(pData_bReqStrb),
        .pData_bRspValid(pData_bRspValid), .pData_bRspReady(pData_bRspReady),
        .pData_bRspData(pData_bRspData), .pData_bRspErr(pData_bRspErr)
    );

    always #5 iClock = ~iClock;

    longint cyc = 0;
    always @(posedge iClock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model: word array plus expected-response queues.
    typedef struct {
        logic [31:0] data;
        logic        err;
        longint      acc;
        int          s0;
    } exp_t;

    logic [31:0] model [WORDS];
    exp_t        qi[$];
    exp_t        qd[$];
    int          scnt_i = 0;
    int          scnt_d = 0;

    function automatic bit addr_bad(input logic [31:0] a);
        longint unsigned ua, ub;
        ua = a;
        ub = BASE;
        return (ua < ub) || (ua % 4 != 0) || ((ua - ub) / 4 >= WORDS);
    endfunction

    function automatic int widx(input logic [31:0] a);
        longint unsigned ua, ub;
        ua = a;
        ub = BASE;
        return int'((ua - ub) / 4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] w;
        w = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = new_w[8*b +: 8];
        return w;
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return BASE + 32'($urandom_range(0, WORDS-1) * 4 + $urandom_range(1, 3));
        if (r == 1) return BASE - 32'($urandom_range(1, 64) * 4);
        if (r == 2) return BASE + 32'((WORDS + $urandom_range(0, 15)) * 4);
        return BASE + 32'($urandom_range(0, WORDS-1) * 4);
    endfunction

    // Accept observer: apply writes first (write-first), then queue expected responses.
    initial forever begin
        exp_t e;
        bit   bad;
        @(negedge iClock);
        if (!iReset) begin
            if (pData_bReqValid && pData_bReqReady) begin
                bad   = addr_bad(pData_bReqAddr);
                e.acc = cyc;
                e.s0  = scnt_d;
                e.err = bad;
                if (pData_bReqWr) begin
                    if (!bad) model[widx(pData_bReqAddr)] =
                        merge(model[widx(pData_bReqAddr)], pData_bReqData, pData_bReqStrb);
                    e.data = 32'h0;
                end else begin
                    e.data = bad ? 32'h0 : model[widx(pData_bReqAddr)];
                end
                qd.push_back(e);
            end
            if (pInst_bReqValid && pInst_bReqReady) begin
                bad    = addr_bad(pInst_bReqAddr);
                e.acc  = cyc;
                e.s0   = scnt_i;
                e.err  = bad;
                e.data = bad ? 32'h0 : model[widx(pInst_bReqAddr)];
                qi.push_back(e);
            end
        end
    end

    // Monitor: compare each completed response against the head of its queue.
    initial forever begin
        exp_t e;
        @(negedge iClock);
        chk("inst_req_ready", pInst_bReqReady, !(pInst_bRspValid && !pInst_bRspReady));
        chk("data_req_ready", pData_bReqReady, !(pData_bRspValid && !pData_bRspReady));

        if (pInst_bRspValid && qi.size() == 0) begin
            checks++; errors++;
            $display("FAIL inst_stray_rsp actual=response required=none");
        end else if (pInst_bRspValid && pInst_bRspReady) begin
            e = qi.pop_front();
            chk("inst_rsp_data", pInst_bRspData, e.data);
            chk("inst_rsp_err", pInst_bRspErr, e.err);
            chk("inst_rsp_cycle", cyc, e.acc + LAT + (scnt_i - e.s0));
        end else if (!pInst_bRspValid && qi.size() != 0 &&
                     cyc >= qi[0].acc + LAT + (scnt_i - qi[0].s0)) begin
            e = qi.pop_front();
            checks++; errors++;
            $display("FAIL inst_missing_rsp actual=none required=response");
        end
        if (pInst_bRspValid && !pInst_bRspReady) scnt_i++;

        if (pData_bRspValid && qd.size() == 0) begin
            checks++; errors++;
            $display("FAIL data_stray_rsp actual=response required=none");
        end else if (pData_bRspValid && pData_bRspReady) begin
            e = qd.pop_front();
            chk("data_rsp_data", pData_bRspData, e.data);
            chk("data_rsp_err", pData_bRspErr, e.err);
            chk("data_rsp_cycle", cyc, e.acc + LAT + (scnt_d - e.s0));
        end else if (!pData_bRspValid && qd.size() != 0 &&
                     cyc >= qd[0].acc + LAT + (scnt_d - qd[0].s0)) begin
            e = qd.pop_front();
            checks++; errors++;
            $display("FAIL data_missing_rsp actual=none required=response");
        end
        if (pData_bRspValid && !pData_bRspReady) scnt_d++;
    end

    task automatic drive(input logic dv, input logic dwr, input logic [31:0] da,
                         input logic [31:0] dd, input logic [3:0] ds,
                         input logic iv, input logic [31:0] ia);
        @(posedge iClock); #1;
        pData_bReqValid = dv;
        pData_bReqWr    = dwr;
        pData_bReqAddr  = da;
        pData_bReqData  = dd;
        pData_bReqStrb  = ds;
        pInst_bReqValid = iv;
        pInst_bReqAddr  = ia;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
        repeat (n) @(posedge iClock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int low_seen;
        iReset = 1'b1;
        pInst_bReqValid = 1'b0; pInst_bReqAddr = '0; pInst_bRspReady = 1'b1;
        pData_bReqValid = 1'b0; pData_bReqWr = 1'b0; pData_bReqAddr = '0;
        pData_bReqData = '0; pData_bReqStrb = '0; pData_bRspReady = 1'b1;
        repeat (2) @(posedge iClock);
        #1;
        chk("rst_inst_rsp_valid", pInst_bRspValid, 0);
        chk("rst_data_rsp_valid", pData_bRspValid, 0);
        chk("rst_inst_req_ready", pInst_bReqReady, 1);
        chk("rst_data_req_ready", pData_bReqReady, 1);
        chk("rst_inst_rsp_data", pInst_bRspData, 0);
        chk("rst_data_rsp_data", pData_bRspData, 0);
        chk("rst_inst_rsp_err", pInst_bRspErr, 0);
        chk("rst_data_rsp_err", pData_bRspErr, 0);
        iReset = 1'b0;

        // Fill every word so the model never sees unknown contents.
        for (int w = 0; w < WORDS; w++) drive(1'b1, 1'b1, BASE + 32'(w * 4), $urandom, 4'hF, 1'b0, 32'h0);
        idle(LAT + 2);

        // Full write then read on both ports.
        drive(1'b1, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        drive(1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'h0, 1'b1, BASE + 32'h10);
        idle(LAT + 2);

        // Partial-strobe merge and a zero-strobe no-op write.
        drive(1'b1, 1'b1, BASE + 32'h20, 32'hAAAAAAAA, 4'hF, 1'b0, 32'h0);
        drive(1'b1, 1'b1, BASE + 32'h20, 32'h11223344, 4'b0011, 1'b0, 32'h0);
        drive(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 1'b1, BASE + 32'h20);
        drive(1'b1, 1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, 1'b0, 32'h0);
        idle(LAT + 2);

        // Same-cycle write and instruction read of the same word.
        drive(1'b1, 1'b1, BASE + 32'h30, 32'h00000055, 4'hF, 1'b1, BASE + 32'h30);
        idle(LAT + 2);

        // Error addresses on both ports; an error write must not touch word 0.
        drive(1'b1, 1'b0, BASE + 32'h2, 32'h0, 4'h0, 1'b1, 32'h7FFFFFFC);
        drive(1'b1, 1'b0, BASE + 32'(4 * WORDS), 32'h0, 4'h0, 1'b1, BASE + 32'h2);
        drive(1'b1, 1'b1, BASE + 32'h2, 32'hFFFFFFFF, 4'hF, 1'b1, BASE + 32'(4 * WORDS));
        drive(1'b1, 1'b1, BASE + 32'(4 * WORDS), 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
        drive(1'b1, 1'b0, BASE, 32'h0, 4'h0, 1'b1, BASE);
        idle(LAT + 2);

        // Back-to-back reads with the response side stalled for five cycles.
        k = 0;
        low_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge iClock); #1;
            pData_bRspReady = !(c >= 3 && c < 8);
            pData_bReqValid = (k < 4);
            pData_bReqWr    = 1'b0;
            pData_bReqAddr  = BASE + 32'(4 * (k + 4));
            #1;
            if (!pData_bReqReady) low_seen++;
            if (k < 4 && pData_bReqReady) k++;
        end
        chk("stall_all_issued", k, 4);
        chk("stall_ready_dropped", low_seen > 0, 1);
        pData_bRspReady = 1'b1;
        idle(LAT + 2);

        // Randomised traffic on both ports with random back-pressure.
        for (int c = 0; c < 500; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), rand_addr());
            pInst_bRspReady = ($urandom_range(0, 3) != 0);
            pData_bRspReady = ($urandom_range(0, 3) != 0);
        end
        pInst_bRspReady = 1'b1;
        pData_bRspReady = 1'b1;
        idle(LAT + 8);
        chk("drain_inst_queue", qi.size(), 0);
        chk("drain_data_queue", qd.size(), 0);

        // Reset while a stalled data response is pending.
        pData_bRspReady = 1'b0;
        drive(1'b1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, BASE + 32'h44, 32'h0, 4'h0, 1'b0, 32'h0);
        idle(1);
        for (int t = 0; t < 10 && !pData_bRspValid; t++) begin
            @(posedge iClock); #1;
        end
        chk("rst_stall_rsp_pending", pData_bRspValid, 1);
        chk("rst_stall_ready_low", pData_bReqReady, 0);
        @(posedge iClock); #3;
        iReset = 1'b1;
        #1;
        chk("rst_async_rsp_valid", pData_bRspValid, 0);
        chk("rst_async_req_ready", pData_bReqReady, 1);
        chk("rst_async_rsp_data", pData_bRspData, 0);
        qd.delete();
        qi.delete();
        @(posedge iClock); #1;
        iReset = 1'b0;
        pData_bRspReady = 1'b1;
        idle(LAT + 6);
        chk("post_rst_req_ready", pData_bReqReady, 1);
        chk("post_rst_rsp_valid", pData_bRspValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
